// File: rtl/hazard_scoreboard_unit_if.sv
// hazard_scoreboard_unit_if: ID decode / EX redirect inputs and pipeline control outputs of the hazard scoreboard.
// Optional macro HAZARD_STATS_EN adds the stall_cycles / flush_cycles statistic outputs.
interface hazard_scoreboard_unit_if #(
    parameter int NUM_REGS = 32,
    parameter int MAX_LAT  = 4
);
    localparam int RA_W  = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(MAX_LAT + 1);
    logic                id_valid;
    logic [6:0]          id_opcode;
    logic [RA_W-1:0]     id_rs1;
    logic [RA_W-1:0]     id_rs2;
    logic [RA_W-1:0]     id_rd;
    logic                id_rd_wr;
    logic [CNT_W-1:0]    id_lat;
    logic                ex_redirect;
    logic                invalid_inst;
    logic                pc_en;
    logic                if_id_en;
    logic                if_id_flush;
    logic                id_ex_en;
    logic                id_ex_flush;
    logic                data_stall;
    logic [NUM_REGS-1:0] sb_busy;
    logic [1:0]          fsm_state;
`ifdef HAZARD_STATS_EN
    logic [15:0]         stall_cycles;
    logic [15:0]         flush_cycles;
`endif
    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, id_rd_wr, id_lat, ex_redirect, invalid_inst,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, data_stall, sb_busy, fsm_state
`ifdef HAZARD_STATS_EN
        , stall_cycles, flush_cycles
`endif
    );
    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, id_rd_wr, id_lat, ex_redirect, invalid_inst,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, data_stall, sb_busy, fsm_state
`ifdef HAZARD_STATS_EN
        , stall_cycles, flush_cycles
`endif
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: per-register countdown scoreboard plus IF/ID/EX stall/flush control with redirect-bubble and halt FSM.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush cycle counters.
module hazard_scoreboard_unit #(
    parameter int NUM_REGS         = 32,
    parameter int MAX_LAT          = 4,
    parameter int REDIRECT_BUBBLES = 0
) (
    input logic                     clk,
    input logic                     rst_n,
    hazard_scoreboard_unit_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_LAT + 1);
    localparam int BUB_W = REDIRECT_BUBBLES > 0 ? $clog2(REDIRECT_BUBBLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAT_MAX  = CNT_W'(MAX_LAT);
    localparam logic [BUB_W-1:0] BUB_LOAD = BUB_W'(REDIRECT_BUBBLES);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [1:0] {S_RUN = 2'b00, S_REDIR = 2'b01, S_HALT = 2'b10} state_t;

    state_t              state_q, state_d;
    logic [BUB_W-1:0]    bub_q, bub_d;
    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [CNT_W-1:0]    lat_clip;
    logic                rs1_used, rs2_used, data_hazard, issue;
    logic                pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, data_stall;
    logic [NUM_REGS-1:0] sb_busy;

    // Which sources the ID instruction reads, and whether any of them is still in flight
    always_comb begin
        rs2_used    = bus.id_opcode inside {OP_R, OP_S, OP_B};
        rs1_used    = rs2_used || (bus.id_opcode inside {OP_I, OP_LD, OP_JALR});
        data_hazard = bus.id_valid && ((rs1_used && cnt_q[bus.id_rs1] != '0) ||
                                       (rs2_used && cnt_q[bus.id_rs2] != '0));
        lat_clip    = bus.id_lat > LAT_MAX ? LAT_MAX : bus.id_lat;
    end

    // Pipeline control: redirect beats data hazard beats illegal instruction; reset forces a full bubble
    always_comb begin
        state_d     = state_q == S_HALT ? S_HALT : S_RUN;
        bub_d       = bub_q;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        data_stall  = 1'b0;
        if (state_q == S_REDIR) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            bub_d       = bus.ex_redirect ? BUB_LOAD : bub_q - BUB_W'(1);
            state_d     = (!bus.ex_redirect && bub_q <= BUB_W'(1)) ? S_RUN : S_REDIR;
        end else if (bus.ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            bub_d       = BUB_LOAD;
            state_d     = REDIRECT_BUBBLES > 0 ? S_REDIR : S_RUN;
        end else if (state_q == S_RUN && data_hazard) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            data_stall  = 1'b1;
        end else if (state_q == S_HALT || bus.invalid_inst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            state_d     = S_HALT;
        end
        if (!rst_n) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            data_stall  = 1'b0;
        end
        issue = bus.id_valid && id_ex_en && !id_ex_flush && bus.id_rd_wr && bus.id_rd != '0;
    end

    // Countdown scoreboard: every counter drains, the newest issue to rd overwrites it, x0 is never tracked
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i]   = cnt_q[i] != '0 ? cnt_q[i] - CNT_W'(1) : '0;
            sb_busy[i] = cnt_q[i] != '0;
        end
        if (issue) cnt_d[bus.id_rd] = lat_clip;
        cnt_d[0] = '0;
    end

    // State, bubble count and scoreboard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            bub_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.if_id_en    = if_id_en;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_en    = id_ex_en;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.data_stall  = data_stall;
    assign bus.sb_busy     = sb_busy;
    assign bus.fsm_state   = state_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_q, stall_d, flush_q, flush_d;

    // Saturating counts of data-stall cycles and of bubbles caused by a redirect or the REDIR window
    always_comb begin
        stall_d = stall_q + 16'(data_stall && stall_q != 16'hFFFF);
        flush_d = flush_q + 16'((state_q == S_REDIR || bus.ex_redirect) && flush_q != 16'hFFFF);
    end

    // Statistic registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.flush_cycles = flush_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: vector table, hand sequences (halt, redirect bubbles, async reset) and a random run against a timestamp model
module tb_hazard_scoreboard_unit;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit_if #(.NUM_REGS(32), .MAX_LAT(4)) bus ();
    hazard_scoreboard_unit_if #(.NUM_REGS(32), .MAX_LAT(4)) bus2 ();

    hazard_scoreboard_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    hazard_scoreboard_unit #(.REDIRECT_BUBBLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        logic       valid;
        logic [6:0] op;
        logic [4:0] rs1, rs2, rd;
        logic       wr;
        logic [2:0] lat;
        logic       redir;
        logic [4:0] chk;
        logic       pc_en, if_flush, ex_flush, stall, busy;
    } vec_t;

    vec_t tbl [31];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic wr, input logic [2:0] lat, input logic redir, input logic inv);
        bus.id_valid     = v;
        bus.id_opcode    = op;
        bus.id_rs1       = r1;
        bus.id_rs2       = r2;
        bus.id_rd        = rd;
        bus.id_rd_wr     = wr;
        bus.id_lat       = lat;
        bus.ex_redirect  = redir;
        bus.invalid_inst = inv;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        tbl[0]  = '{1, OP_LD,   0,  0,  5, 1, 1, 0,  5, 1, 0, 0, 0, 0};
        tbl[1]  = '{1, OP_R,    5,  0,  6, 1, 0, 0,  5, 0, 0, 1, 1, 1};
        tbl[2]  = '{1, OP_R,    5,  0,  6, 1, 0, 0,  5, 1, 0, 0, 0, 0};
        tbl[3]  = '{1, OP_R,    1,  2,  7, 1, 4, 0,  7, 1, 0, 0, 0, 0};
        tbl[4]  = '{1, OP_S,    0,  7,  0, 0, 0, 0,  7, 0, 0, 1, 1, 1};
        tbl[5]  = '{1, OP_S,    0,  7,  0, 0, 0, 0,  7, 0, 0, 1, 1, 1};
        tbl[6]  = '{1, OP_S,    0,  7,  0, 0, 0, 0,  7, 0, 0, 1, 1, 1};
        tbl[7]  = '{1, OP_S,    0,  7,  0, 0, 0, 0,  7, 0, 0, 1, 1, 1};
        tbl[8]  = '{1, OP_S,    0,  7,  0, 0, 0, 0,  7, 1, 0, 0, 0, 0};
        tbl[9]  = '{1, OP_R,    8,  8,  9, 1, 6, 0,  9, 1, 0, 0, 0, 0};
        tbl[10] = '{1, OP_I,    9,  0, 10, 1, 0, 0,  9, 0, 0, 1, 1, 1};
        tbl[11] = '{1, OP_I,    9,  0, 10, 1, 0, 0,  9, 0, 0, 1, 1, 1};
        tbl[12] = '{1, OP_I,    9,  0, 10, 1, 0, 0,  9, 0, 0, 1, 1, 1};
        tbl[13] = '{1, OP_I,    9,  0, 10, 1, 0, 0,  9, 0, 0, 1, 1, 1};
        tbl[14] = '{1, OP_I,    9,  0, 10, 1, 0, 0,  9, 1, 0, 0, 0, 0};
        tbl[15] = '{1, OP_R,    0,  0,  3, 1, 4, 0,  3, 1, 0, 0, 0, 0};
        tbl[16] = '{1, OP_R,    0,  0,  3, 1, 1, 0,  3, 1, 0, 0, 0, 1};
        tbl[17] = '{1, OP_I,    3,  0, 11, 1, 0, 0,  3, 0, 0, 1, 1, 1};
        tbl[18] = '{1, OP_I,    3,  0, 11, 1, 0, 0,  3, 1, 0, 0, 0, 0};
        tbl[19] = '{1, OP_R,    0,  0,  0, 1, 3, 0,  0, 1, 0, 0, 0, 0};
        tbl[20] = '{1, OP_I,    0,  0, 11, 1, 0, 0,  0, 1, 0, 0, 0, 0};
        tbl[21] = '{1, OP_LD,   0,  0, 12, 1, 2, 0, 12, 1, 0, 0, 0, 0};
        tbl[22] = '{1, OP_B,    1, 12,  0, 0, 0, 1, 12, 1, 1, 1, 0, 1};
        tbl[23] = '{1, OP_B,    1, 12,  0, 0, 0, 0, 12, 0, 0, 1, 1, 1};
        tbl[24] = '{1, OP_B,    1, 12,  0, 0, 0, 0, 12, 1, 0, 0, 0, 0};
        tbl[25] = '{0, OP_R,    5,  5,  5, 1, 4, 0,  5, 1, 0, 0, 0, 0};
        tbl[26] = '{1, OP_I,    5,  0,  0, 0, 0, 0,  5, 1, 0, 0, 0, 0};
        tbl[27] = '{1, OP_LD,   0,  0, 13, 1, 2, 0, 13, 1, 0, 0, 0, 0};
        tbl[28] = '{1, OP_LUI, 13, 13, 14, 1, 0, 0, 13, 1, 0, 0, 0, 1};
        tbl[29] = '{1, OP_JALR,13,  0,  1, 1, 0, 0, 13, 0, 0, 1, 1, 1};
        tbl[30] = '{1, OP_JALR,13,  0,  1, 1, 0, 0, 13, 1, 0, 0, 0, 0};

        drive(0, OP_R, 0, 0, 0, 0, 0, 0, 0);
        bus2.id_valid = 1'b0; bus2.id_opcode = OP_R; bus2.id_rs1 = '0; bus2.id_rs2 = '0; bus2.id_rd = '0;
        bus2.id_rd_wr = 1'b0; bus2.id_lat = '0; bus2.ex_redirect = 1'b0; bus2.invalid_inst = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc_en",       32'(bus.pc_en), 0);
        chk("rst_if_id_en",    32'(bus.if_id_en), 0);
        chk("rst_id_ex_en",    32'(bus.id_ex_en), 0);
        chk("rst_if_id_flush", 32'(bus.if_id_flush), 1);
        chk("rst_id_ex_flush", 32'(bus.id_ex_flush), 1);
        chk("rst_sb_busy",     bus.sb_busy, 0);
        chk("rst_fsm_state",   32'(bus.fsm_state), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 31; i++) begin
            drive(tbl[i].valid, tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].wr, tbl[i].lat, tbl[i].redir, 0);
            @(negedge clk);
            chk($sformatf("row%0d_pc_en", i),       32'(bus.pc_en), 32'(tbl[i].pc_en));
            chk($sformatf("row%0d_if_id_en", i),    32'(bus.if_id_en), 32'(tbl[i].pc_en));
            chk($sformatf("row%0d_id_ex_en", i),    32'(bus.id_ex_en), 1);
            chk($sformatf("row%0d_if_id_flush", i), 32'(bus.if_id_flush), 32'(tbl[i].if_flush));
            chk($sformatf("row%0d_id_ex_flush", i), 32'(bus.id_ex_flush), 32'(tbl[i].ex_flush));
            chk($sformatf("row%0d_data_stall", i),  32'(bus.data_stall), 32'(tbl[i].stall));
            chk($sformatf("row%0d_busy", i),        32'(bus.sb_busy[tbl[i].chk]), 32'(tbl[i].busy));
            chk($sformatf("row%0d_fsm", i),         32'(bus.fsm_state), 0);
            tick();
        end

        drive(1, OP_LD, 0, 0, 13, 1, 4, 0, 0);
        tick();
        drive(1, OP_I, 0, 0, 2, 1, 0, 0, 1);
        @(negedge clk);
        chk("inv_pc_en",       32'(bus.pc_en), 0);
        chk("inv_id_ex_flush", 32'(bus.id_ex_flush), 1);
        chk("inv_fsm",         32'(bus.fsm_state), 0);
        tick();
        drive(1, OP_I, 0, 0, 2, 1, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("halt%0d_fsm", k),   32'(bus.fsm_state), 2);
            chk($sformatf("halt%0d_pc_en", k), 32'(bus.pc_en), 0);
            chk($sformatf("halt%0d_ifen", k),  32'(bus.if_id_en), 0);
            tick();
        end
        chk("halt_drained", bus.sb_busy, 0);
        drive(1, OP_I, 0, 0, 2, 1, 0, 1, 0);
        @(negedge clk);
        chk("halt_exit_if_flush", 32'(bus.if_id_flush), 1);
        chk("halt_exit_ex_flush", 32'(bus.id_ex_flush), 1);
        chk("halt_exit_pc_en",    32'(bus.pc_en), 1);
        tick();
        drive(1, OP_I, 0, 0, 2, 1, 0, 0, 0);
        @(negedge clk);
        chk("halt_exit_fsm",   32'(bus.fsm_state), 0);
        chk("halt_exit_pc_en2", 32'(bus.pc_en), 1);
        tick();

        bus2.ex_redirect = 1'b1;
        @(negedge clk);
        chk("b2_redir_fsm",   32'(bus2.fsm_state), 0);
        chk("b2_redir_flush", 32'(bus2.if_id_flush), 1);
        tick();
        bus2.ex_redirect = 1'b0;
        @(negedge clk);
        chk("b2_bub1_fsm",   32'(bus2.fsm_state), 1);
        chk("b2_bub1_flush", 32'({bus2.if_id_flush, bus2.id_ex_flush, bus2.pc_en}), 7);
        tick();
        @(negedge clk);
        chk("b2_bub2_fsm", 32'(bus2.fsm_state), 1);
        tick();
        @(negedge clk);
        chk("b2_done_fsm",  32'(bus2.fsm_state), 0);
        chk("b2_done_ctrl", 32'({bus2.if_id_flush, bus2.id_ex_flush, bus2.pc_en}), 1);
        bus2.ex_redirect = 1'b1;
        tick();
        @(negedge clk);
        chk("b2_reload_in_fsm", 32'(bus2.fsm_state), 1);
        tick();
        bus2.ex_redirect = 1'b0;
        @(negedge clk);
        chk("b2_reload_a_fsm", 32'(bus2.fsm_state), 1);
        tick();
        @(negedge clk);
        chk("b2_reload_b_fsm", 32'(bus2.fsm_state), 1);
        tick();
        @(negedge clk);
        chk("b2_reload_end_fsm", 32'(bus2.fsm_state), 0);
        tick();

        drive(1, OP_LD, 0, 0, 5, 1, 4, 0, 0);
        tick();
        drive(1, OP_R, 5, 0, 6, 1, 0, 0, 0);
        @(negedge clk);
        chk("ar_pre_stall", 32'(bus.data_stall), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy",     bus.sb_busy, 0);
        chk("ar_fsm",      32'(bus.fsm_state), 0);
        chk("ar_pc_en",    32'(bus.pc_en), 0);
        chk("ar_id_ex_en", 32'(bus.id_ex_en), 0);
        chk("ar_stall",    32'(bus.data_stall), 0);
        chk("ar_if_flush", 32'(bus.if_id_flush), 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ar_rel_pc_en", 32'(bus.pc_en), 1);
        chk("ar_rel_stall", 32'(bus.data_stall), 0);
        tick();

        do_reset();
        begin
            int         ready [32];
            int         t;
            logic       halt;
            logic [6:0] ops [8];
            ops = '{OP_R, OP_S, OP_B, OP_I, OP_LD, OP_JALR, OP_LUI, 7'b1101111};
            for (int r = 0; r < 32; r++) ready[r] = 0;
            t    = 0;
            halt = 1'b0;
            for (int n = 0; n < 600; n++) begin
                logic        v, wr, rd_x, inv, hz, r1u, r2u;
                logic        e_pc, e_iff, e_eff, e_st;
                logic [6:0]  op;
                logic [4:0]  r1, r2, rd;
                logic [2:0]  lat;
                logic [31:0] e_busy;
                v    = $urandom_range(0, 5) != 0;
                op   = ops[$urandom_range(0, 7)];
                r1   = 5'($urandom_range(0, 7));
                r2   = 5'($urandom_range(0, 7));
                rd   = 5'($urandom_range(0, 7));
                wr   = $urandom_range(0, 3) != 0;
                lat  = 3'($urandom_range(0, 7));
                rd_x = $urandom_range(0, 15) == 0;
                inv  = $urandom_range(0, 24) == 0;
                drive(v, op, r1, r2, rd, wr, lat, rd_x, inv);
                e_busy = '0;
                for (int r = 1; r < 32; r++) e_busy[r] = ready[r] > t;
                r2u = op == OP_R || op == OP_S || op == OP_B;
                r1u = r2u || op == OP_I || op == OP_LD || op == OP_JALR;
                hz  = v && ((r1u && e_busy[r1]) || (r2u && e_busy[r2]));
                e_st = 1'b0;
                if (rd_x) begin
                    e_pc = 1'b1; e_iff = 1'b1; e_eff = 1'b1;
                end else if (halt) begin
                    e_pc = 1'b0; e_iff = 1'b0; e_eff = 1'b1;
                end else if (hz) begin
                    e_pc = 1'b0; e_iff = 1'b0; e_eff = 1'b1; e_st = 1'b1;
                end else if (inv) begin
                    e_pc = 1'b0; e_iff = 1'b0; e_eff = 1'b1;
                end else begin
                    e_pc = 1'b1; e_iff = 1'b0; e_eff = 1'b0;
                end
                @(negedge clk);
                chk($sformatf("rnd%0d_fsm", n),    32'(bus.fsm_state), halt ? 2 : 0);
                chk($sformatf("rnd%0d_pc_en", n),  32'(bus.pc_en), 32'(e_pc));
                chk($sformatf("rnd%0d_ifen", n),   32'(bus.if_id_en), 32'(e_pc));
                chk($sformatf("rnd%0d_exen", n),   32'(bus.id_ex_en), 1);
                chk($sformatf("rnd%0d_iff", n),    32'(bus.if_id_flush), 32'(e_iff));
                chk($sformatf("rnd%0d_eff", n),    32'(bus.id_ex_flush), 32'(e_eff));
                chk($sformatf("rnd%0d_stall", n),  32'(bus.data_stall), 32'(e_st));
                chk($sformatf("rnd%0d_busy", n),   bus.sb_busy, e_busy);
                if (v && !e_eff && wr && rd != 0) ready[rd] = t + 1 + (lat > 4 ? 4 : int'(lat));
                if (rd_x) halt = 1'b0;
                else if (!halt && !hz && inv) halt = 1'b1;
                tick();
                t++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the single-cycle load-use hazard unit.
- Tracks a per-register countdown scoreboard of in-flight multi-cycle writers, so loads, MUL/DIV and other long-latency ops are handled uniformly.
- Generates IF/ID/EX pipeline enables and flushes, including a multi-cycle redirect flush and an invalid-instruction halt FSM.
- Sits beside the ID stage; consumes ID decode fields plus EX redirect/trap signals.

Parameters:
- NUM_REGS, 32, architectural registers; index width RA_W = $clog2(NUM_REGS); x0 never tracked.
- MAX_LAT, 4, largest result latency in cycles until the value is forwardable.
- CNT_W, $clog2(MAX_LAT+1), countdown width.
- REDIRECT_BUBBLES, 0, extra flush cycles after a redirect (0 = legacy 2-bubble penalty).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  7  ID opcode
- id_rs1  in  RA_W  ID source 1
- id_rs2  in  RA_W  ID source 2
- id_rd  in  RA_W  ID destination
- id_rd_wr  in  1  ID instruction writes rd
- id_lat  in  CNT_W  cycles until the result is forwardable (load = 1, ALU = 0)
- ex_redirect  in  1  EX redirects PC (taken branch/jump/trap target)
- invalid_inst  in  1  ID instruction is illegal
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID flush
- id_ex_en  out  1  ID/EX register enable
- id_ex_flush  out  1  ID/EX flush (inserts bubble)
- data_stall  out  1  scoreboard stall active
- sb_busy  out  NUM_REGS  bit i set when counter[i] != 0
- fsm_state  out  2  00 RUN, 01 REDIR, 10 HALT

Behaviour:
- Source usage:
  - rs2 used for R, S, B opcodes.
  - rs1 used for those plus I-ALU, load, JALR.
- data_hazard = id_valid && ((rs1_used && counter[id_rs1] != 0) || (rs2_used && counter[id_rs2] != 0)).
- Counters:
  - Reset to 0.
  - Every cycle, each nonzero counter decrements by 1.
  - Issue occurs when id_valid && id_ex_en && !id_ex_flush && id_rd_wr && id_rd != 0; on issue, counter[id_rd] loads min(id_lat, MAX_LAT) instead of decrementing.
  - Issuing to an rd that is already busy overwrites its counter (WAW: newest writer wins).
  - Counter[0] is constant 0.
- Default outputs: pc_en=1, if_id_en=1, id_ex_en=1, both flushes 0, data_stall=0.
- RUN state, evaluated in priority order:
  - ex_redirect: if_id_flush=1, id_ex_flush=1, pc_en=1. Go to REDIR if REDIRECT_BUBBLES>0 (load bubble count), else stay in RUN.
  - data_hazard: pc_en=0, if_id_en=0, id_ex_flush=1, data_stall=1. Repeats each cycle until the counter reaches 0; no issue occurs while stalled.
  - invalid_inst: id_ex_flush=1, pc_en=0, if_id_en=0; go to HALT.
- REDIR state:
  - Both flushes = 1, pc_en=1.
  - Decrement bubble count; return to RUN after it reaches 0.
  - ex_redirect in REDIR reloads the bubble count.
- HALT state:
  - pc_en=0, if_id_en=0, id_ex_flush=1.
  - Counters keep draining.
  - Exit to RUN only on ex_redirect, which applies the RUN redirect outputs that cycle.
- Simultaneous ex_redirect and data_hazard: redirect wins; the stalled instruction is flushed and never issues.
- Reset mid-operation (rst_n low): counters=0, state=RUN, pc_en=0, if_id_en=0, id_ex_en=0, if_id_flush=1, id_ex_flush=1, data_stall=0, sb_busy=0.
- Outputs are combinational from state, counters and inputs; state and counters are registered.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - Adds outputs stall_cycles[15:0] and flush_cycles[15:0].
  - stall_cycles counts cycles with data_stall=1.
  - flush_cycles counts cycles with id_ex_flush=1 caused by redirect or REDIR.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Load-use: issue load rd=5, id_lat=1, next ID is add rs1=5 -> exactly 1 cycle data_stall=1, pc_en=0, id_ex_flush=1, then the add issues; sb_busy[5] clears after 1 cycle.
- Long-latency: div rd=7, id_lat=4, then dependent store rs2=7 -> 4 stall cycles.
  - Independent instruction using x8 -> 0 stall cycles.
  - id_lat=6 with MAX_LAT=4 -> 4 stall cycles.
- WAW/x0:
  - Issue lat=4 to x3, then lat=1 to x3 -> counter[3]=1 and the dependent stalls 1 cycle.
  - Write to x0 with lat=3 -> no stall for an rs1=x0 consumer.
- Redirect priority:
  - ex_redirect together with data_hazard -> both flushes=1, pc_en=1, data_stall=0.
  - With REDIRECT_BUBBLES=2: fsm_state=01 for 2 cycles, then 00.
- Invalid instruction: invalid_inst=1 -> fsm_state=10, pc_en=0 held for 10 cycles; ex_redirect -> flushes=1, returns to 00.
- Async reset: assert rst_n=0 mid-stall with sb_busy nonzero -> sb_busy=0, fsm_state=00, pc_en=0 immediately (no clock edge); after release, pc_en=1.
